// File: rtl/branch_sequencer_pkg.sv
// Shared CPU control definitions: T-step state encoding, branch opcode and
// opcode field location, and the datapath strobe bundle.
package branch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6
  } state_t;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic ir_in;
    logic mdr_out;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic add;
  } strobes_t;

  function automatic logic is_branch(input logic [31:0] ir, input logic [4:0] opcode);
    return ir[OPC_HI:OPC_LO] == opcode;
  endfunction

endpackage

// File: rtl/branch_step_decode.sv
// Combinational decode of the sequencer state into datapath strobes and status;
// con_in only matters in T6, where it gates PCin and taken.
module branch_step_decode
  import branch_sequencer_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  state_t              state,
  input  logic                con_in,
  input  logic                br_hit,
  output strobes_t            strb,
  output logic [STEP_W-1:0]   step,
  output logic                busy,
  output logic                done,
  output logic                taken,
  output logic                unsupported
);

  always_comb begin
    strb        = '0;
    step        = '0;
    busy        = 1'b1;
    done        = 1'b0;
    taken       = 1'b0;
    unsupported = 1'b0;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_T0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.z_in   = 1'b1;
      end
      ST_T1: begin
        step          = STEP_W'(1);
        strb.zlow_out = 1'b1;
        strb.pc_in    = 1'b1;
        strb.read     = 1'b1;
        strb.mdr_in   = 1'b1;
      end
      ST_T2: begin
        step         = STEP_W'(2);
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
        // A non-branch ends here, so completion is flagged in the same cycle.
        done         = ~br_hit;
        unsupported  = ~br_hit;
      end
      ST_T3: begin
        step        = STEP_W'(3);
        strb.gra    = 1'b1;
        strb.r_out  = 1'b1;
        strb.con_in = 1'b1;
      end
      ST_T4: begin
        step        = STEP_W'(4);
        strb.pc_out = 1'b1;
        strb.y_in   = 1'b1;
      end
      ST_T5: begin
        step       = STEP_W'(5);
        strb.c_out = 1'b1;
        strb.add   = 1'b1;
        strb.z_in  = 1'b1;
      end
      ST_T6: begin
        step          = STEP_W'(6);
        strb.zlow_out = 1'b1;
        strb.pc_in    = con_in;
        taken         = con_in;
        done          = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Control-unit sequencer for instruction fetch plus conditional branch
// execution (T0..T6); outputs are decoded from the registered state.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE = BR_OPCODE_DEF,
  parameter int         STEP_W    = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [31:0]       ir_in,
  input  logic              mem_ready,
  input  logic              con_in,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Zin,
  output logic              Zlowout,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              IRin,
  output logic              MDRout,
  output logic              Gra,
  output logic              Rout,
  output logic              CONin,
  output logic              Yin,
  output logic              Cout,
  output logic              ADD,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              unsupported
);

  state_t   state;
  strobes_t strb;
  logic     br_hit;

  assign br_hit = is_branch(ir_in, BR_OPCODE);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (mem_ready) state <= ST_T2;
        ST_T2:   state <= br_hit ? ST_T3 : ST_IDLE;
        ST_T3:   state <= ST_T4;
        ST_T4:   state <= ST_T5;
        ST_T5:   state <= ST_T6;
        ST_T6:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  branch_step_decode #(
    .STEP_W(STEP_W)
  ) u_decode (
    .state      (state),
    .con_in     (con_in),
    .br_hit     (br_hit),
    .strb       (strb),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .taken      (taken),
    .unsupported(unsupported)
  );

  assign PCout   = strb.pc_out;
  assign MARin   = strb.mar_in;
  assign IncPC   = strb.inc_pc;
  assign Zin     = strb.z_in;
  assign Zlowout = strb.zlow_out;
  assign PCin    = strb.pc_in;
  assign Read    = strb.read;
  assign MDRin   = strb.mdr_in;
  assign IRin    = strb.ir_in;
  assign MDRout  = strb.mdr_out;
  assign Gra     = strb.gra;
  assign Rout    = strb.r_out;
  assign CONin   = strb.con_in;
  assign Yin     = strb.y_in;
  assign Cout    = strb.c_out;
  assign ADD     = strb.add;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: each instruction is planned as a list of T-steps
// and every cycle's strobes and status are compared against that plan.
module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10010;

  logic        clk = 1'b0;
  logic        clear, start, mem_ready, con_in;
  logic [31:0] ir_in;
  logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic        IRin, MDRout, Gra, Rout, CONin, Yin, Cout, ADD;
  logic [2:0]  step;
  logic        busy, done, taken, unsupported;
  logic [15:0] strobes;

  int checks   = 0;
  int failures = 0;

  branch_sequencer dut (
    .clk(clk), .clear(clear), .start(start), .ir_in(ir_in),
    .mem_ready(mem_ready), .con_in(con_in),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
    .IRin(IRin), .MDRout(MDRout), .Gra(Gra), .Rout(Rout),
    .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD),
    .step(step), .busy(busy), .done(done), .taken(taken),
    .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  assign strobes = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                    IRin, MDRout, Gra, Rout, CONin, Yin, Cout, ADD};

  // Register-transfer table of the fetch/branch microprogram, one row per T-step.
  function automatic logic [15:0] step_strobes(input int s, input bit c);
    case (s)
      0:       return 16'hF000;
      1:       return 16'h0F00;
      2:       return 16'h00C0;
      3:       return 16'h0038;
      4:       return 16'h8004;
      5:       return 16'h1003;
      6:       return c ? 16'h0C00 : 16'h0800;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] non_branch_word();
    logic [4:0] opc;
    opc = 5'($urandom);
    if (opc == BR) opc = ~opc;
    return {opc, 27'($urandom)};
  endfunction

  // One instruction from an IDLE cycle; 'stall' cycles of mem_ready=0 in T1.
  task automatic run_instr(input string name, input bit br, input int stall,
                           input bit con, input bit hold, input logic [31:0] instr);
    int          seq[$];
    int          cur, nxt, t1_seen;
    logic [22:0] exp_v, act_v;
    t1_seen = 0;
    seq.push_back(0);
    for (int k = 0; k <= stall; k++) seq.push_back(1);
    seq.push_back(2);
    if (br) for (int s = 3; s <= 6; s++) seq.push_back(s);

    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || strobes !== 16'h0 || step !== 3'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle busy=%0b strobes=%h step=%0d done=%0b required all 0",
               name, busy, strobes, step, done);
    end
    clear     = 1'b0;
    start     = 1'b1;
    mem_ready = 1'($urandom);
    con_in    = 1'($urandom);
    ir_in     = $urandom;

    for (int i = 0; i < seq.size(); i++) begin
      cur = seq[i];
      nxt = (i + 1 < seq.size()) ? seq[i+1] : -1;
      @(negedge clk);
      exp_v = {step_strobes(cur, con), 3'(cur), 1'b1, (i == seq.size() - 1),
               (cur == 6) && con, (!br) && (cur == 2)};
      act_v = {strobes, step, busy, done, taken, unsupported};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s cycle=%0d strobes/step/busy/done/taken/unsup got=%h required=%h",
                 name, i, act_v, exp_v);
      end
      start     = hold ? 1'b1 : 1'($urandom);
      mem_ready = (cur == 1) ? (t1_seen < stall ? 1'b0 : 1'b1) : 1'($urandom);
      if (cur == 1) t1_seen++;
      ir_in     = (cur == 2 || nxt == 2) ? instr : $urandom;
      con_in    = (cur == 6 || nxt == 6) ? con : 1'($urandom);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b1; mem_ready = 1'b1; con_in = 1'b1;
    ir_in = 32'h9080_0023;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({strobes, step, busy, done, taken, unsupported} !== 23'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0",
               {strobes, step, busy, done, taken, unsupported});
    end
    clear = 1'b0; start = 1'b0;
  endtask

  task automatic test_clear_mid();
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b1; con_in = 1'b1; ir_in = 32'h9080_0023;
    repeat (5) @(negedge clk);
    checks++;
    if (step !== 3'd4 || strobes !== 16'h8004) begin
      failures++;
      $display("FAIL clear_mid_reach_t4 step=%0d strobes=%h required 4/8004", step, strobes);
    end
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if ({strobes, step, busy, done, taken, unsupported} !== 23'h0) begin
      failures++;
      $display("FAIL clear_mid_idle got=%h required=0",
               {strobes, step, busy, done, taken, unsupported});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || step !== 3'd0) begin
      failures++;
      $display("FAIL clear_over_start busy=%0b step=%0d required 0/0", busy, step);
    end
    clear = 1'b0; start = 1'b0;
  endtask

  task automatic test_clear_stall();
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b0; ir_in = 32'h9080_0023;
    repeat (3) @(negedge clk);
    checks++;
    if (step !== 3'd1 || strobes !== 16'h0F00) begin
      failures++;
      $display("FAIL clear_stall_in_t1 step=%0d strobes=%h required 1/0f00", step, strobes);
    end
    clear = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || strobes !== 16'h0 || step !== 3'd0) begin
      failures++;
      $display("FAIL clear_stall_idle busy=%0b strobes=%h step=%0d required 0", busy, strobes, step);
    end
    clear = 1'b0; start = 1'b0;
  endtask

  task automatic test_branch_taken();
    run_instr("brzr_taken", 1'b1, 0, 1'b1, 1'b0, 32'h9080_0023);
    start = 1'b0;
  endtask

  task automatic test_branch_not_taken();
    run_instr("brnz_not_taken", 1'b1, 0, 1'b0, 1'b0, 32'h9088_0023);
    start = 1'b0;
  endtask

  task automatic test_mem_stall();
    run_instr("mem_stall", 1'b1, 3, 1'b1, 1'b0, 32'h9080_0023);
    start = 1'b0;
  endtask

  task automatic test_non_branch();
    run_instr("non_branch", 1'b0, 0, 1'b0, 1'b0, 32'h1800_0000);
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_a", 1'b1, 0, 1'b1, 1'b1, 32'h9080_0023);
    run_instr("b2b_b", 1'b1, 1, 1'b0, 1'b1, 32'h9088_0023);
    run_instr("b2b_c", 1'b0, 0, 1'b0, 1'b1, non_branch_word());
    start = 1'b0;
  endtask

  task automatic test_random();
    bit br;
    for (int n = 0; n < 12; n++) begin
      br = 1'($urandom);
      run_instr("random", br, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                br ? {BR, 27'($urandom)} : non_branch_word());
    end
    start = 1'b0;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; con_in = 1'b0; ir_in = '0;
    test_reset();
    test_branch_taken();
    test_branch_not_taken();
    test_mem_stall();
    test_non_branch();
    test_clear_mid();
    test_clear_stall();
    test_back_to_back();
    test_random();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL final_idle busy=%0b required 0", busy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
